status_reporter: RTL and testbench

//  Host-bound telemetry framer on the FT245 simple-interface TX path (tx_data_si/tx_valid_si/tx_ready_si).

---
 rtl/status_reporter_pkg.sv | 41 ++++
 rtl/status_reporter_if.sv | 16 +
 rtl/status_reporter_sat_counter.sv | 42 ++++
 rtl/status_reporter.sv | 192 +++++++++++++++++++
 tb/tb_status_reporter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/status_reporter_pkg.sv
// -----------------------------------------------------------------------------
// status_reporter_pkg
//   Shared constants and types for the status_reporter telemetry framer:
//   frame marker and length, FSM state encoding, MODULATION code range,
//   snapshot frame layout and the frame checksum helper.
// -----------------------------------------------------------------------------
package status_reporter_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         FRAME_LEN     = 7;
   localparam int         CNT_W         = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // MODULATION code range carried in byte 1 (1 = AM .. 5 = 8PSK)
   localparam logic [2:0] MOD_AM   = 3'd1;
   localparam logic [2:0] MOD_8PSK = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   // Values frozen in the LOAD cycle and streamed out during SEND
   typedef struct packed {
      logic [3:0]       seq;
      logic             full;
      logic [2:0]       mod;
      logic [CNT_W-1:0] rx;
      logic [CNT_W-1:0] urun;
      logic [7:0]       csum;
   } frame_t;

   // XOR of frame bytes 1..5
   function automatic logic [7:0] frame_csum(input logic [7:0]       b1,
                                             input logic [CNT_W-1:0] rx,
                                             input logic [CNT_W-1:0] urun);
      return b1 ^ rx[15:8] ^ rx[7:0] ^ urun[15:8] ^ urun[7:0];
   endfunction

endpackage

// File: rtl/status_reporter_if.sv
// -----------------------------------------------------------------------------
// status_reporter_if
//   Byte-stream TX handshake toward the FT245 simple interface.
//   tx_data  : byte presented to the FT245 TX port
//   tx_valid : tx_data is valid
//   tx_ready : FT245 accepts the byte this cycle
//   master = status_reporter side, slave = ft245 TX side.
// -----------------------------------------------------------------------------
interface status_reporter_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/status_reporter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   16-bit saturating event counter with synchronous window clear.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clr_i  : start a new window; an event in the same cycle loads 1
//   evt_i  : one-cycle event strobe
//   cnt_o  : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter
   import status_reporter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             evt_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         // the clearing cycle already belongs to the new window
         cnt_d = evt_i ? CNT_W'(1) : '0;
      end else if (evt_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/status_reporter.sv
// -----------------------------------------------------------------------------
// status_reporter
//   Host-bound telemetry framer. Counts sample-FIFO writes, modulator
//   underruns and FIFO-full occurrences and, every CLKS_PER_REPORT cycles
//   while enabled, sends a 7-byte status frame on the FT245 TX path:
//     A5 | {seq,full_seen,mod_code} | rx_hi | rx_lo | urun_hi | urun_lo | xor
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     enable        : periodic reporting active
//     mod_code      : current MODULATION code
//     fifo_wr       : byte written into sample FIFO
//     fifo_rd_req   : modulator read request
//     fifo_empty    : sample FIFO empty (with fifo_rd_req -> underrun)
//     fifo_full     : sample FIFO full
//     tx            : byte stream handshake (master)
//     busy          : frame in LOAD or SEND
// -----------------------------------------------------------------------------
module status_reporter
   import status_reporter_pkg::*;
#(
   parameter int         CLKS_PER_REPORT = 12000000,
   parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEF
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [2:0]               mod_code,
   input  logic                     fifo_wr,
   input  logic                     fifo_rd_req,
   input  logic                     fifo_empty,
   input  logic                     fifo_full,
   status_reporter_if.master        tx,
   output logic                     busy
);

   localparam int            TW         = (CLKS_PER_REPORT > 1) ? $clog2(CLKS_PER_REPORT) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_REPORT - 1);
   localparam logic [2:0]    IDX_LAST   = 3'(FRAME_LEN - 1);

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             pending_q, pending_d;
   logic             full_seen_q, full_seen_d;
   logic [3:0]       seq_q, seq_d;
   logic [2:0]       idx_q, idx_d;
   frame_t           frame_q, frame_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;

   logic             tick, accept, last_byte, load_en, send_done;
   logic [1:0]       evt;
   logic [CNT_W-1:0] cnt [2];
   logic [2:0]       sel;
   logic [7:0]       byte_mux;
   logic [7:0]       snap_b1;

   // ---- event counters: [0] = sample writes, [1] = underruns ----
   assign evt[0] = fifo_wr;
   assign evt[1] = fifo_rd_req & fifo_empty;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         sat_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (load_en),
            .evt_i (evt[gi]),
            .cnt_o (cnt[gi])
         );
      end
   endgenerate

   assign tick      = enable && (timer_q == TIMER_LAST);
   assign accept    = tx_valid_q && tx.tx_ready;
   assign last_byte = (idx_q == IDX_LAST);

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (tick || pending_q) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_SEND;
         ST_SEND: if (accept && last_byte) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      busy      = (state_q != ST_IDLE);
      load_en   = (state_q == ST_LOAD);
      send_done = (state_q == ST_SEND) && accept && last_byte;
   end

   // ---- frame byte mux: selects the byte that goes out after the next edge ----
   assign sel = load_en ? 3'd0 : (idx_q + 3'd1);

   always_comb begin
      byte_mux = 8'h00;
      case (sel)
         3'd0: byte_mux = SYNC_BYTE;
         3'd1: byte_mux = {frame_q.seq, frame_q.full, frame_q.mod};
         3'd2: byte_mux = frame_q.rx[15:8];
         3'd3: byte_mux = frame_q.rx[7:0];
         3'd4: byte_mux = frame_q.urun[15:8];
         3'd5: byte_mux = frame_q.urun[7:0];
         3'd6: byte_mux = frame_q.csum;
         default: byte_mux = 8'h00;
      endcase
   end

   // ---- datapath next state ----
   assign snap_b1 = {seq_q, full_seen_q, mod_code};

   always_comb begin
      timer_d     = (!enable || tick) ? '0 : timer_q + TW'(1);
      pending_d   = pending_q;
      full_seen_d = full_seen_q | fifo_full;
      seq_d       = seq_q;
      idx_d       = idx_q;
      frame_d     = frame_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;

      // IDLE consumes any pending request; a tick during a frame is remembered once
      if (state_q == ST_IDLE) begin
         pending_d = 1'b0;
      end else if (tick) begin
         pending_d = 1'b1;
      end

      if (load_en) begin
         full_seen_d  = fifo_full;
         frame_d.seq  = seq_q;
         frame_d.full = full_seen_q;
         frame_d.mod  = mod_code;
         frame_d.rx   = cnt[0];
         frame_d.urun = cnt[1];
         frame_d.csum = frame_csum(snap_b1, cnt[0], cnt[1]);
         idx_d        = 3'd0;
         tx_valid_d   = 1'b1;
         tx_data_d    = byte_mux;
      end else if ((state_q == ST_SEND) && accept) begin
         if (last_byte) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = byte_mux;
         end
      end

      if (send_done) begin
         seq_d = seq_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q     <= '0;
         pending_q   <= 1'b0;
         full_seen_q <= 1'b0;
         seq_q       <= 4'd0;
         idx_q       <= 3'd0;
         frame_q     <= '0;
         tx_data_q   <= 8'h00;
         tx_valid_q  <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         pending_q   <= pending_d;
         full_seen_q <= full_seen_d;
         seq_q       <= seq_d;
         idx_q       <= idx_d;
         frame_q     <= frame_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
      end
   end

   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_status_reporter.sv
// -----------------------------------------------------------------------------
// tb_status_reporter
//   Scoreboard bench for status_reporter with a 64-cycle report period.
//   Expected frame bytes are queued when the stimulus for a window is driven
//   and popped by a monitor on every accepted byte.
// -----------------------------------------------------------------------------
module tb_status_reporter;
   import status_reporter_pkg::*;

   localparam int CPR = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [2:0] mod_code;
   logic       fifo_wr, fifo_rd_req, fifo_empty, fifo_full;
   logic       busy;

   status_reporter_if sr_if();

   status_reporter #(
      .CLKS_PER_REPORT (CPR),
      .SYNC_BYTE       (8'hA5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .mod_code    (mod_code),
      .fifo_wr     (fifo_wr),
      .fifo_rd_req (fifo_rd_req),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .tx          (sr_if),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] sb_q[$];
   logic [3:0] exp_seq = 4'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_evts();
      fifo_wr     = 1'b0;
      fifo_rd_req = 1'b0;
      fifo_empty  = 1'b0;
      fifo_full   = 1'b0;
   endtask

   task automatic push_frame(input logic full, input logic [2:0] mod,
                             input logic [15:0] rx, input logic [15:0] urun);
      logic [7:0] b [7];
      b[0] = 8'hA5;
      b[1] = {exp_seq, full, mod};
      b[2] = rx[15:8];
      b[3] = rx[7:0];
      b[4] = urun[15:8];
      b[5] = urun[7:0];
      b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
      for (int i = 0; i < 7; i++) sb_q.push_back(b[i]);
      $display("queued frame: %h %h %h %h %h %h %h", b[0], b[1], b[2], b[3], b[4], b[5], b[6]);
      exp_seq = exp_seq + 4'd1;
   endtask

   // One report window from a fresh timer; returns in the LOAD cycle.
   // Includes non-events (rd_req without empty, empty without rd_req).
   task automatic run_window(input int wr_n, input int ur_n, input int full_at,
                             input logic [2:0] mod, output int unsigned c0);
      mod_code = mod;
      enable   = 1'b1;
      c0       = cyc;
      for (int k = 0; k < CPR; k++) begin
         fifo_wr     = (k >= 2) && (k < 2 + wr_n);
         fifo_rd_req = ((k >= 20) && (k < 20 + ur_n)) || ((k >= 50) && (k < 53));
         fifo_empty  = ((k >= 20) && (k < 20 + ur_n)) || ((k >= 40) && (k < 43));
         fifo_full   = (k == full_at);
         step();
      end
      clear_evts();
   endtask

   // Called in the LOAD cycle: checks LOAD outputs and first-byte latency
   task automatic check_start(input int unsigned c0, input logic wr_in_load);
      chk("load_busy", busy, 1);
      chk("load_valid", sr_if.tx_valid, 0);
      fifo_wr = wr_in_load;
      step();
      fifo_wr = 1'b0;
      chk("first_valid", sr_if.tx_valid, 1);
      chk("latency", cyc - c0, CPR + 1);
      chk("send_busy", busy, 1);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (((sb_q.size() != 0) || sr_if.tx_valid) && (n < budget)) begin
         step();
         n++;
      end
      chk("drain_done", ((sb_q.size() == 0) && !sr_if.tx_valid), 1);
   endtask

   task automatic stop();
      enable = 1'b0;
      step();
   endtask

   // ---- monitor: scoreboard pop, handshake stability, frame length ----
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   int         fr_cnt     = 0;
   logic [7:0] exp_b;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         fr_cnt     = 0;
      end else begin
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", sr_if.tx_valid, 1);
            chk("hold_data", sr_if.tx_data, prev_data);
         end
         if (prev_valid && !sr_if.tx_valid) begin
            chk("frame_len", fr_cnt, 7);
            $display("frame done: %0d bytes at cycle %0d", fr_cnt, cyc);
            fr_cnt = 0;
         end
         if (sr_if.tx_valid && sr_if.tx_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", sb_q.size(), 1);
            end else begin
               exp_b = sb_q.pop_front();
               chk("byte", sr_if.tx_data, exp_b);
            end
            fr_cnt++;
         end
         prev_valid = sr_if.tx_valid;
         prev_ready = sr_if.tx_ready;
         prev_data  = sr_if.tx_data;
      end
   end

   // ---- stimulus ----
   initial begin
      int unsigned c0;
      int          fall_k, rise_k;
      logic        seen;
      int          n;

      rst            = 1'b1;
      enable         = 1'b0;
      mod_code       = 3'd0;
      sr_if.tx_ready = 1'b1;
      clear_evts();
      step();
      step();
      chk("rst_valid", sr_if.tx_valid, 0);
      chk("rst_data", sr_if.tx_data, 8'h00);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      step();

      // basic frame: 10 writes, mod 3 -> A5 03 00 0A 00 00 09
      run_window(10, 0, -1, 3'd3, c0);
      push_frame(1'b0, 3'd3, 16'd10, 16'd0);
      check_start(c0, 1'b0);
      wait_drain(40);
      stop();

      // 3 underruns and a full pulse
      run_window(0, 3, 30, 3'd3, c0);
      push_frame(1'b1, 3'd3, 16'd0, 16'd3);
      check_start(c0, 1'b0);
      wait_drain(40);
      stop();

      // random back-pressure
      run_window(5, 2, -1, 3'd5, c0);
      push_frame(1'b0, 3'd5, 16'd5, 16'd2);
      check_start(c0, 1'b0);
      n = 0;
      while (((sb_q.size() != 0) || sr_if.tx_valid) && (n < 50)) begin
         sr_if.tx_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      chk("rand_drain", ((sb_q.size() == 0) && !sr_if.tx_valid), 1);
      sr_if.tx_ready = 1'b1;
      stop();

      // long stall across ticks at k=127 and k=191: exactly one pending frame
      mod_code = 3'd1;
      enable   = 1'b1;
      c0       = cyc;
      fall_k   = -1;
      rise_k   = -1;
      push_frame(1'b0, 3'd1, 16'd2, 16'd0);
      push_frame(1'b0, 3'd1, 16'd4, 16'd0);
      for (int k = 0; k < 216; k++) begin
         if ((k >= 200) && !sr_if.tx_valid && (fall_k < 0)) fall_k = k;
         if ((fall_k >= 0) && sr_if.tx_valid && (rise_k < 0)) rise_k = k;
         if (k == 150) chk("stall_busy", busy, 1);
         fifo_wr        = (k == 10) || (k == 11) || ((k >= 100) && (k < 104));
         sr_if.tx_ready = (k >= 200);
         step();
      end
      fifo_wr = 1'b0;
      chk("pend_gap", rise_k - fall_k, 2);
      stop();
      seen = 1'b0;
      for (int k = 0; k < 80; k++) begin
         seen = seen | sr_if.tx_valid;
         step();
      end
      chk("no_third_frame", seen, 0);
      chk("sb_empty", sb_q.size(), 0);

      // saturate both counters while reporting is off, event in LOAD cycle
      fifo_wr     = 1'b1;
      fifo_rd_req = 1'b1;
      fifo_empty  = 1'b1;
      for (int k = 0; k < 70000; k++) step();
      clear_evts();
      run_window(0, 0, -1, 3'd4, c0);
      push_frame(1'b0, 3'd4, 16'hFFFF, 16'hFFFF);
      check_start(c0, 1'b1);
      wait_drain(40);
      stop();
      run_window(3, 0, -1, 3'd4, c0);
      push_frame(1'b0, 3'd4, 16'd4, 16'd0);
      check_start(c0, 1'b0);
      wait_drain(40);
      stop();

      // reset in the middle of a stalled frame
      sr_if.tx_ready = 1'b0;
      run_window(1, 0, -1, 3'd2, c0);
      push_frame(1'b0, 3'd2, 16'd1, 16'd0);
      check_start(c0, 1'b0);
      step();
      step();
      enable = 1'b0;
      rst    = 1'b1;
      sb_q.delete();
      step();
      rst     = 1'b0;
      exp_seq = 4'd0;
      chk("rst_mid_valid", sr_if.tx_valid, 0);
      chk("rst_mid_data", sr_if.tx_data, 8'h00);
      chk("rst_mid_busy", busy, 0);
      sr_if.tx_ready = 1'b1;
      step();
      run_window(2, 1, 5, 3'd2, c0);
      push_frame(1'b1, 3'd2, 16'd2, 16'd1);
      check_start(c0, 1'b0);
      wait_drain(40);
      stop();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
